// File: rtl/alu_seq_handshake.sv
// Registered, handshaked ALU with an accumulator and an iterative shift-add multiplier.
// One operand bundle is accepted in IDLE; results are held in DONE until the consumer takes them.
module alu_seq_handshake #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               use_acc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               flag_z,
  output logic               flag_c,
  output logic               flag_n,
  output logic               flag_v,
  output logic [WIDTH-1:0]   acc,
  output logic               busy
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned DW  = 2 * WIDTH;
  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR,
    OP_ASR, OP_ROL, OP_ROR, OP_MUL, OP_PASS, OP_INC, OP_DEC, OP_CLR
  } op_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [DW-1:0]    prod;
  logic [SHW-1:0]   cnt;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb_arith;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [DW-1:0]    rol_t;
  logic [DW-1:0]    ror_t;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [DW-1:0]    mul_term;
  logic [DW-1:0]    prod_nxt;

  // Single-cycle datapath for every opcode except MUL
  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    opa       = use_acc ? acc : a;
    shamt     = b[SHW-1:0];
    opb_arith = (op_t'(op) == OP_INC || op_t'(op) == OP_DEC) ? WIDTH'(1) : b;
    sum       = {1'b0, opa} + {1'b0, opb_arith};
    diff      = {1'b0, opa} - {1'b0, opb_arith};
    rol_t     = {opa, opa} << shamt;
    ror_t     = {opa, opa} >> shamt;
    case (op_t'(op))
      OP_ADD, OP_INC: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (opa[MSB] == opb_arith[MSB]) && (alu_res[MSB] != opa[MSB]);
      end
      OP_SUB, OP_DEC: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (opa[MSB] != opb_arith[MSB]) && (alu_res[MSB] != opa[MSB]);
      end
      OP_AND:  alu_res = opa & b;
      OP_OR:   alu_res = opa | b;
      OP_XOR:  alu_res = opa ^ b;
      OP_NOT:  alu_res = ~opa;
      OP_SHL:  alu_res = opa << shamt;
      OP_SHR:  alu_res = opa >> shamt;
      OP_ASR:  alu_res = WIDTH'($signed(opa) >>> shamt);
      OP_ROL:  alu_res = rol_t[DW-1:WIDTH];
      OP_ROR:  alu_res = ror_t[WIDTH-1:0];
      OP_PASS: alu_res = b;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: add the multiplicand shifted by the step index when the current bit is set
  always_comb begin
    mul_term = mplier[0] ? (DW'(mcand) << cnt) : '0;
    prod_nxt = prod + mul_term;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (op_t'(op) == OP_MUL) begin
              mcand  <= opa;
              mplier <= b;
              prod   <= '0;
              cnt    <= '0;
              state  <= S_MUL;
            end else begin
              result    <= {{WIDTH{1'b0}}, alu_res};
              flag_z    <= (alu_res == '0);
              flag_c    <= alu_c;
              flag_n    <= alu_res[MSB];
              flag_v    <= alu_v;
              acc       <= alu_res;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_MUL: begin
          prod   <= prod_nxt;
          mplier <= mplier >> 1;
          cnt    <= cnt + SHW'(1);
          if (cnt == SHW'(WIDTH - 1)) begin
            result    <= prod_nxt;
            flag_z    <= (prod_nxt == '0);
            flag_c    <= |prod_nxt[DW-1:WIDTH];
            flag_n    <= prod_nxt[DW-1];
            flag_v    <= 1'b0;
            acc       <= prod_nxt[WIDTH-1:0];
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_handshake.sv
// Randomized bench for alu_seq_handshake (WIDTH=8) against an arithmetic reference model.
module tb_alu_seq_handshake;

  localparam int unsigned W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          use_acc;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] result;
  logic          flag_z, flag_c, flag_n, flag_v;
  logic [W-1:0]  acc;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int acc_m    = 0;

  alu_seq_handshake #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .use_acc(use_acc), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
    .flag_v(flag_v), .acc(acc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference behaviour from the opcode table, in plain integer arithmetic
  task automatic model(input int opc, input int av, input int bv,
                       output int r, output bit z, output bit c, output bit n, output bit v);
    int s, sr;
    s = bv % W;
    c = 0; v = 0; r = 0;
    case (opc)
      0, 13: begin
        if (opc == 13) bv = 1;
        r = av + bv; c = (r > 255); sr = to_signed(av) + to_signed(bv);
        v = (sr > 127) || (sr < -128); r = r % 256;
      end
      1, 14: begin
        if (opc == 14) bv = 1;
        r = av - bv; c = (av < bv); sr = to_signed(av) - to_signed(bv);
        v = (sr > 127) || (sr < -128); r = (r + 256) % 256;
      end
      2:  r = av & bv;
      3:  r = av | bv;
      4:  r = av ^ bv;
      5:  r = 255 - av;
      6:  r = (av * (1 << s)) % 256;
      7:  r = av / (1 << s);
      8:  r = (to_signed(av) >>> s) & 255;
      9:  r = ((av << s) | (av >> (8 - s))) & 255;
      10: r = ((av >> s) | (av << (8 - s))) & 255;
      11: begin r = av * bv; c = (r > 255); end
      12: r = bv;
      default: r = 0;
    endcase
    z = (r == 0);
    n = (opc == 11) ? (r >= 32768) : (r >= 128);
  endtask

  task automatic do_op(input int opc, input int av, input int bv, input bit ua, input int hold);
    int er, lat, t, ea;
    bit ez, ec, en, ev, rdy_low, stable;
    logic [15:0] r0;
    logic [3:0]  f0;
    ea = ua ? acc_m : av;
    model(opc, ea, bv, er, ez, ec, en, ev);
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    check("in_ready_idle", 32'(in_ready), 32'd1);
    op = 4'(opc); a = 8'(av); b = 8'(bv); use_acc = ua; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
    use_acc = 1'($urandom);
    lat = 1; rdy_low = 1;
    while (!out_valid && lat < 50) begin
      rdy_low &= (!in_ready) && busy;
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    out_ready = 1'b0;
    check($sformatf("latency op%0d", opc), 32'(lat), (opc == 11) ? 32'd9 : 32'd1);
    check("busy_wait", 32'(rdy_low), 32'd1);
    check("done_state", {30'd0, in_ready, busy}, 32'd1);
    check($sformatf("result op%0d A=%0h B=%0h", opc, ea, bv), 32'(result), 32'(er));
    check($sformatf("flags op%0d A=%0h B=%0h", opc, ea, bv),
          {28'd0, flag_z, flag_c, flag_n, flag_v}, {28'd0, ez, ec, en, ev});
    acc_m = er & 255;
    check("acc", 32'(acc), 32'(acc_m));
    r0 = result; f0 = {flag_z, flag_c, flag_n, flag_v};
    stable = 1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      stable &= out_valid && !in_ready && (result == r0) && ({flag_z, flag_c, flag_n, flag_v} == f0);
    end
    if (hold > 0) check("backpressure_stable", 32'(stable), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release", {29'd0, out_valid, in_ready, busy}, 32'b010);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; use_acc = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {9'd0, out_valid, busy, flag_z, flag_c, flag_n, flag_v, result},
          32'd0);
    check("reset_acc", 32'(acc), 32'd0);
    @(negedge clk); rst = 1'b0;
    #1 check("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Reset in the middle of a multiply
    do_op(0, 8'h12, 8'h34, 0, 0);
    @(negedge clk);
    op = 4'd11; a = 8'hFF; b = 8'hFF; use_acc = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_mid_mul", {6'd0, busy, out_valid, result, acc}, 32'd0);
    @(negedge clk); rst = 1'b0; acc_m = 0;
    #1 check("in_ready_after_mid_reset", 32'(in_ready), 32'd1);
    do_op(0, 8'h03, 8'h04, 0, 0);

    // Boundaries: wrap, overflow, full-scale multiply, long backpressure
    do_op(0, 8'hFF, 8'h01, 0, 0);
    check("add_wrap_flags", {28'd0, flag_z, flag_c, flag_n, flag_v}, 32'b1100);
    do_op(0, 8'h7F, 8'h01, 0, 0);
    do_op(11, 8'hFF, 8'hFF, 0, 5);
    do_op(1, 8'h00, 8'h01, 0, 0);

    // Accumulator chain
    do_op(15, 8'h5A, 8'hA5, 0, 0);
    for (int i = 0; i < 3; i++) do_op(0, 8'hEE, 8'h05, 1, 0);
    check("acc_chain", 32'(acc), 32'h0F);
    do_op(1, 8'h00, 8'h10, 1, 0);
    check("acc_sub_borrow", {23'd0, flag_c, acc}, 32'h1FF);

    // Shifts and rotates on 0x81 by 1 and by 0
    for (int s = 1; s >= 0; s--)
      for (int o = 6; o <= 10; o++) do_op(o, 8'h81, s, 0, 0);

    // Random operations with random backpressure
    for (int i = 0; i < 150; i++)
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), 1'($urandom), int'($urandom_range(0, 3)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
